// File: rtl/gpu2d_pkg.sv
// Shared constants and types for the 2D pixel pipeline blocks.
package gpu2d_pkg;

  // Default parallel word width and per-beat width for the serializer.
  localparam int SER_WORD_W = 16;
  localparam int SER_OUT_W  = 1;

  // Serializer bit order; the encoding matches the MSB_FIRST parameter value.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } ser_order_e;

endpackage

// File: rtl/pixel_serializer.sv
// Parallel-to-serial pixel word serializer with a one-word holding buffer.
// A shift stage emits OUT_W bits per beat; a second word can wait in the
// holding buffer so back-to-back words stream without idle beats.
module pixel_serializer
  import gpu2d_pkg::*;
#(
  parameter int WORD_W    = SER_WORD_W,
  parameter int OUT_W     = SER_OUT_W,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              idle
);

  localparam int BEATS = WORD_W / OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam ser_order_e ORDER = ser_order_e'(MSB_FIRST != 0);

  logic [WORD_W-1:0] shift_data;
  logic [CNT_W-1:0]  cnt;
  logic              shift_full;
  logic [WORD_W-1:0] hold_data;
  logic              hold_full;

  logic in_fire;
  logic out_fire;
  logic at_last;
  logic load_direct;

  assign in_ready  = !hold_full;
  assign out_valid = shift_full;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign at_last   = (cnt == LAST_CNT);
  assign out_first = shift_full && (cnt == '0);
  assign out_last  = shift_full && at_last;
  assign idle      = !shift_full && !hold_full;

  // in_fire already implies the holding buffer is empty, so an accepted word
  // bypasses it whenever the shift stage is empty or is finishing this edge.
  assign load_direct = in_fire && (!shift_full || (out_fire && at_last));

  // Present the beat at the emitting end; zero whenever no beat is live.
  always_comb begin
    out_data = '0;
    if (shift_full) begin
      if (ORDER == gpu2d_pkg::MSB_FIRST) begin
        out_data = shift_data[WORD_W-1 -: OUT_W];
      end else begin
        out_data = shift_data[OUT_W-1:0];
      end
    end
  end

  // Shift stage: advance one beat per output transfer, refill on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_data <= '0;
      cnt        <= '0;
      shift_full <= 1'b0;
    end else if (out_fire) begin
      if (!at_last) begin
        if (ORDER == gpu2d_pkg::MSB_FIRST) begin
          shift_data <= shift_data << OUT_W;
        end else begin
          shift_data <= shift_data >> OUT_W;
        end
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (hold_full) begin
          shift_data <= hold_data;
        end else if (in_fire) begin
          shift_data <= in_data;
        end else begin
          shift_data <= '0;
          shift_full <= 1'b0;
        end
      end
    end else if (load_direct) begin
      shift_data <= in_data;
      cnt        <= '0;
      shift_full <= 1'b1;
    end
  end

  // Holding buffer: captures a word the shift stage cannot take yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (out_fire && at_last && hold_full) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (in_fire && !load_direct) begin
      hold_data <= in_data;
      hold_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed and randomized checks of pixel_serializer in three configurations:
// A = 8-bit word, 1-bit LSB-first; B = 8-bit, 2-bit MSB-first; C = 8-bit, 8-bit.
module tb_pixel_serializer;

  logic clk = 1'b0;
  logic rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_first, a_out_last, a_idle;
  logic [7:0] a_in_data;
  logic [0:0] a_out_data;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_first, b_out_last, b_idle;
  logic [7:0] b_in_data;
  logic [1:0] b_out_data;

  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_first, c_out_last, c_idle;
  logic [7:0] c_in_data;
  logic [7:0] c_out_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_serializer #(.WORD_W(8), .OUT_W(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_first(a_out_first), .out_last(a_out_last), .idle(a_idle)
  );

  pixel_serializer #(.WORD_W(8), .OUT_W(2), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_first(b_out_first), .out_last(b_out_last), .idle(b_idle)
  );

  pixel_serializer #(.WORD_W(8), .OUT_W(8), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_first(c_out_first), .out_last(c_out_last), .idle(c_idle)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 1'b0 ||
        a_out_first !== 1'b0 || a_out_last !== 1'b0 || a_idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_a: got rdy=%b vld=%b data=%b first=%b last=%b idle=%b expected 1 0 0 0 0 1",
               a_in_ready, a_out_valid, a_out_data, a_out_first, a_out_last, a_idle);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== 2'd0 || b_idle !== 1'b1 || b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_b: got vld=%b data=%0d idle=%b rdy=%b expected 0 0 1 1",
               b_out_valid, b_out_data, b_idle, b_in_ready);
    end
    checks++;
    if (c_out_valid !== 1'b0 || c_out_data !== 8'h00 || c_idle !== 1'b1 || c_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_c: got vld=%b data=%h idle=%b rdy=%b expected 0 00 1 1",
               c_out_valid, c_out_data, c_idle, c_in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb_word();
    logic [7:0] w;
    w = 8'hA5;
    a_in_data = w; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data[0] !== w[b] ||
          a_out_first !== (b == 0) || a_out_last !== (b == 7)) begin
        failures++;
        $display("FAIL lsb_beat%0d: got vld=%b data=%b first=%b last=%b expected 1 %b %b %b",
                 b, a_out_valid, a_out_data, a_out_first, a_out_last, w[b], (b == 0), (b == 7));
      end
      @(negedge clk);
    end
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 1'b0 || a_idle !== 1'b1) begin
      failures++;
      $display("FAIL underrun: got vld=%b data=%b idle=%b expected 0 0 1", a_out_valid, a_out_data, a_idle);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_beats [8];
    exp_beats = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0};
    b_in_data = 8'hA5; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== exp_beats[i] ||
          b_out_first !== ((i % 4) == 0) || b_out_last !== ((i % 4) == 3)) begin
        failures++;
        $display("FAIL b2b_beat%0d: got vld=%b data=%0d first=%b last=%b expected 1 %0d %b %b",
                 i, b_out_valid, b_out_data, b_out_first, b_out_last, exp_beats[i],
                 ((i % 4) == 0), ((i % 4) == 3));
      end
      if (i == 1) begin
        checks++;
        if (b_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_hold_ready: got %b expected 0", b_in_ready);
        end
      end
      if (i == 0) b_in_data = 8'h3C;
      else        b_in_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_idle !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: got vld=%b idle=%b expected 0 1", b_out_valid, b_idle);
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] w, v;
    w = 8'hA5; v = 8'h3C;
    a_in_data = w; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_out_data[0] !== w[i]) begin
        failures++;
        $display("FAIL bp_pre%0d: got %b expected %b", i, a_out_data, w[i]);
      end
      if (i == 2) begin
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = v;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data[0] !== w[2] || a_out_first !== 1'b0 ||
          a_in_ready !== 1'b0 || a_idle !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: got vld=%b data=%b first=%b rdy=%b idle=%b expected 1 %b 0 0 0",
                 k, a_out_valid, a_out_data, a_out_first, a_in_ready, a_idle, w[2]);
      end
      a_in_valid = 1'b0;
      if (k == 2) a_out_ready = 1'b1;
      @(negedge clk);
    end
    for (int i = 3; i < 8; i++) begin
      checks++;
      if (a_out_data[0] !== w[i] || a_in_ready !== 1'b0 || a_out_last !== (i == 7)) begin
        failures++;
        $display("FAIL bp_post%0d: got data=%b rdy=%b last=%b expected %b 0 %b",
                 i, a_out_data, a_in_ready, a_out_last, w[i], (i == 7));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data[0] !== v[i] || a_out_first !== (i == 0) ||
          a_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_second%0d: got vld=%b data=%b first=%b rdy=%b expected 1 %b %b 1",
                 i, a_out_valid, a_out_data, a_out_first, a_in_ready, v[i], (i == 0));
      end
      @(negedge clk);
    end
    checks++;
    if (a_out_valid !== 1'b0 || a_idle !== 1'b1) begin
      failures++;
      $display("FAIL bp_end: got vld=%b idle=%b expected 0 1", a_out_valid, a_idle);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w, n;
    w = 8'hA5; n = 8'h0F;
    a_in_data = w; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_data = 8'h3C;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_out_data[0] !== w[4] || a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got data=%b rdy=%b vld=%b expected %b 0 1",
               a_out_data, a_in_ready, a_out_valid, w[4]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_idle !== 1'b1 || a_out_data !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got vld=%b rdy=%b idle=%b data=%b expected 0 1 1 0",
               a_out_valid, a_in_ready, a_idle, a_out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_after: got vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
    end
    a_in_data = n; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data[0] !== n[i] || a_out_first !== (i == 0)) begin
        failures++;
        $display("FAIL rst_new_beat%0d: got vld=%b data=%b first=%b expected 1 %b %b",
                 i, a_out_valid, a_out_data, a_out_first, n[i], (i == 0));
      end
      @(negedge clk);
    end
    checks++;
    if (a_out_valid !== 1'b0 || a_idle !== 1'b1) begin
      failures++;
      $display("FAIL rst_new_end: got vld=%b idle=%b expected 0 1", a_out_valid, a_idle);
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_single_beat();
    c_in_data = 8'h5A; c_in_valid = 1'b1; c_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (c_out_valid !== 1'b1 || c_out_data !== 8'h5A || c_out_first !== 1'b1 || c_out_last !== 1'b1) begin
      failures++;
      $display("FAIL single_w0: got vld=%b data=%h first=%b last=%b expected 1 5a 1 1",
               c_out_valid, c_out_data, c_out_first, c_out_last);
    end
    c_in_data = 8'hC3;
    @(negedge clk);
    c_in_valid = 1'b0;
    checks++;
    if (c_out_valid !== 1'b1 || c_out_data !== 8'hC3 || c_out_first !== 1'b1 ||
        c_out_last !== 1'b1 || c_idle !== 1'b0) begin
      failures++;
      $display("FAIL single_w1: got vld=%b data=%h first=%b last=%b idle=%b expected 1 c3 1 1 0",
               c_out_valid, c_out_data, c_out_first, c_out_last, c_idle);
    end
    @(negedge clk);
    checks++;
    if (c_out_valid !== 1'b0 || c_out_data !== 8'h00 || c_idle !== 1'b1) begin
      failures++;
      $display("FAIL single_end: got vld=%b data=%h idle=%b expected 0 00 1", c_out_valid, c_out_data, c_idle);
    end
    c_out_ready = 1'b0;
  endtask

  // Random valid/ready traffic on one configuration, scored against a queue
  // of expected beats built from the accepted words.
  task automatic test_random(input int sel, input int nwords);
    logic [7:0] q[$];
    logic [7:0] w, exp_beat, od;
    logic       vld, rdy, ir, ov;
    int         sent, cycles;
    sent = 0; cycles = 0;
    w = 8'($urandom);
    while ((sent < nwords || q.size() != 0) && cycles < 20000) begin
      vld = (sent < nwords) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      case (sel)
        0:       begin a_in_valid = vld; a_in_data = w; a_out_ready = rdy; end
        1:       begin b_in_valid = vld; b_in_data = w; b_out_ready = rdy; end
        default: begin c_in_valid = vld; c_in_data = w; c_out_ready = rdy; end
      endcase
      #1;
      case (sel)
        0:       begin ir = a_in_ready; ov = a_out_valid; od = {7'd0, a_out_data}; end
        1:       begin ir = b_in_ready; ov = b_out_valid; od = {6'd0, b_out_data}; end
        default: begin ir = c_in_ready; ov = c_out_valid; od = c_out_data; end
      endcase
      if (ov && rdy) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand%0d_extra: got beat %h expected no beat", sel, od);
        end else begin
          exp_beat = q.pop_front();
          if (od !== exp_beat) begin
            failures++;
            $display("FAIL rand%0d_beat: got %h expected %h", sel, od, exp_beat);
          end
        end
      end else if (!ov && od !== 8'h00) begin
        checks++;
        failures++;
        $display("FAIL rand%0d_idle_data: got %h expected 00", sel, od);
      end
      if (vld && ir) begin
        case (sel)
          0:       for (int k = 0; k < 8; k++) q.push_back({7'd0, w[k]});
          1:       for (int k = 0; k < 4; k++) q.push_back((w >> (6 - 2 * k)) & 8'h03);
          default: q.push_back(w);
        endcase
        sent++;
        w = 8'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
    checks++;
    if (cycles >= 20000 || sent != nwords) begin
      failures++;
      $display("FAIL rand%0d_timeout: got sent=%0d pending=%0d expected sent=%0d pending=0",
               sel, sent, q.size(), nwords);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    test_reset();
    test_lsb_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_single_beat();
    test_random(0, 150);
    test_random(1, 150);
    test_random(2, 150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
